// File: rtl/bjt_sweep_scheduler.sv
// Two-level I-V sweep sequencer: base DAC outer loop, collector DAC inner loop, settle, ADC, tagged record.
// Optional BJT_SWEEP_AVG4_EN averages four conversions per point.
module bjt_sweep_scheduler #(
  parameter int         DAC_W    = 16,
  parameter int         ADC_W    = 12,
  parameter int         IDX_W    = 8,
  parameter int         SETTLE_W = 16,
  parameter logic [1:0] BASE_CH  = 2'd0,
  parameter logic [1:0] COLL_CH  = 2'd1
) (
  input  logic                       globalclock,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [DAC_W-1:0]           base_start,
  input  logic [DAC_W-1:0]           base_step,
  input  logic [IDX_W-1:0]           base_count,
  input  logic [DAC_W-1:0]           coll_start,
  input  logic [DAC_W-1:0]           coll_step,
  input  logic [IDX_W-1:0]           coll_count,
  input  logic [SETTLE_W-1:0]        settle_cycles,
  output logic                       dac_req,
  output logic [1:0]                 dac_channel,
  output logic [DAC_W-1:0]           dac_code,
  input  logic                       dac_ack,
  output logic                       adc_start,
  input  logic                       adc_done,
  input  logic [ADC_W-1:0]           adc_data,
  output logic                       rec_valid,
  output logic [2*IDX_W+ADC_W-1:0]   rec_data,
  input  logic                       rec_ready,
  output logic                       busy,
  output logic                       done,
  output logic [3:0]                 dbg_state
);
  // DAC handshake: dac_req rises with a stable channel/code and stays high until the
  // cycle dac_ack is seen; it is low the following cycle. Records use valid/ready: the
  // record transfers in the cycle rec_valid & rec_ready, and is held unchanged until then.
  localparam int REC_W = 2*IDX_W+ADC_W;
  localparam int PW    = DAC_W+IDX_W+1;

  typedef enum logic [3:0] {
    S_IDLE, S_SET_BASE, S_SET_COLL, S_SETTLE, S_CONVERT,
    S_WAIT_ADC, S_EMIT, S_NEXT, S_PARK_COLL, S_PARK_BASE
  } state_t;

  state_t               r_state;
  logic [DAC_W-1:0]     r_base_start, r_base_step, r_coll_start, r_coll_step;
  logic [IDX_W-1:0]     r_base_count, r_coll_count, r_base_idx, r_coll_idx;
  logic [SETTLE_W-1:0]  r_settle, r_cnt;
  logic                 r_abort_pend;
  logic                 r_dac_req, r_adc_start, r_rec_valid, r_done;
  logic [1:0]           r_dac_channel;
  logic [DAC_W-1:0]     r_dac_code;
  logic [REC_W-1:0]     r_rec_data;
`ifdef BJT_SWEEP_AVG4_EN
  logic [ADC_W+1:0]     r_acc;
  logic [1:0]           r_pass;
  logic [ADC_W+1:0]     w_sum;
  assign w_sum = r_acc + (ADC_W+2)'(adc_data);
`endif

  // Full-width start + idx*step, clamped to all-ones instead of wrapping.
  function automatic logic [DAC_W-1:0] sat_code(input logic [DAC_W-1:0] s,
                                                input logic [IDX_W-1:0] i,
                                                input logic [DAC_W-1:0] st);
    logic [PW-1:0] f;
    f = PW'(s) + PW'(i) * PW'(st);
    return (|f[PW-1:DAC_W]) ? {DAC_W{1'b1}} : f[DAC_W-1:0];
  endfunction

  logic [DAC_W-1:0] w_base_code, w_coll_code;
  logic             w_abort, w_coll_last, w_base_last;
  assign w_base_code = sat_code(r_base_start, r_base_idx, r_base_step);
  assign w_coll_code = sat_code(r_coll_start, r_coll_idx, r_coll_step);
  assign w_abort     = abort | r_abort_pend;
  assign w_coll_last = (r_coll_idx == r_coll_count - IDX_W'(1));
  assign w_base_last = (r_base_idx == r_base_count - IDX_W'(1));

  always_ff @(posedge globalclock) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_base_start <= '0; r_base_step <= '0; r_base_count <= '0;
      r_coll_start <= '0; r_coll_step <= '0; r_coll_count <= '0;
      r_settle <= '0; r_cnt <= '0; r_base_idx <= '0; r_coll_idx <= '0;
      r_abort_pend <= 1'b0;
      r_dac_req <= 1'b0; r_dac_channel <= '0; r_dac_code <= '0;
      r_adc_start <= 1'b0; r_rec_valid <= 1'b0; r_rec_data <= '0; r_done <= 1'b0;
`ifdef BJT_SWEEP_AVG4_EN
      r_acc <= '0; r_pass <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_base_start <= base_start; r_base_step <= base_step; r_base_count <= base_count;
          r_coll_start <= coll_start; r_coll_step <= coll_step; r_coll_count <= coll_count;
          r_settle <= settle_cycles; r_base_idx <= '0; r_coll_idx <= '0;
          r_abort_pend <= 1'b0;
          r_dac_req <= 1'b1;
          if (base_count == '0 || coll_count == '0) begin
            r_state <= S_PARK_COLL; r_dac_channel <= COLL_CH; r_dac_code <= '0;
          end else begin
            r_state <= S_SET_BASE; r_dac_channel <= BASE_CH; r_dac_code <= base_start;
          end
        end
        S_SET_BASE: begin
          if (!r_dac_req) begin
            if (w_abort) begin
              r_state <= S_PARK_COLL; r_abort_pend <= 1'b0;
            end else begin
              r_dac_req <= 1'b1; r_dac_channel <= BASE_CH; r_dac_code <= w_base_code;
            end
          end else if (dac_ack) begin
            r_dac_req <= 1'b0; r_abort_pend <= 1'b0;
            r_state <= w_abort ? S_PARK_COLL : S_SET_COLL;
          end else if (abort) begin
            r_abort_pend <= 1'b1;
          end
        end
        S_SET_COLL: begin
          if (!r_dac_req) begin
            if (w_abort) begin
              r_state <= S_PARK_COLL; r_abort_pend <= 1'b0;
            end else begin
              r_dac_req <= 1'b1; r_dac_channel <= COLL_CH; r_dac_code <= w_coll_code;
            end
          end else if (dac_ack) begin
            r_dac_req <= 1'b0; r_abort_pend <= 1'b0;
`ifdef BJT_SWEEP_AVG4_EN
            r_acc <= '0; r_pass <= '0;
`endif
            if (w_abort) begin
              r_state <= S_PARK_COLL;
            end else if (r_settle == '0) begin
              r_state <= S_CONVERT; r_adc_start <= 1'b1;
            end else begin
              r_state <= S_SETTLE; r_cnt <= r_settle;
            end
          end else if (abort) begin
            r_abort_pend <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            r_state <= S_PARK_COLL;
          end else if (r_cnt == SETTLE_W'(1)) begin
            r_state <= S_CONVERT; r_adc_start <= 1'b1;
          end else begin
            r_cnt <= r_cnt - SETTLE_W'(1);
          end
        end
        S_CONVERT: begin
          r_adc_start <= 1'b0;
          r_state <= abort ? S_PARK_COLL : S_WAIT_ADC;
        end
        S_WAIT_ADC: begin
          if (abort) begin
            r_state <= S_PARK_COLL;
          end else if (adc_done) begin
`ifdef BJT_SWEEP_AVG4_EN
            if (r_pass == 2'd3) begin
              r_rec_data <= {r_base_idx, r_coll_idx, w_sum[ADC_W+1:2]};
              r_rec_valid <= 1'b1; r_state <= S_EMIT;
            end else begin
              r_acc <= w_sum; r_pass <= r_pass + 2'd1;
              r_adc_start <= 1'b1; r_state <= S_CONVERT;
            end
`else
            r_rec_data <= {r_base_idx, r_coll_idx, adc_data};
            r_rec_valid <= 1'b1; r_state <= S_EMIT;
`endif
          end
        end
        S_EMIT: begin
          if (abort) begin
            r_rec_valid <= 1'b0; r_state <= S_PARK_COLL;
          end else if (rec_ready) begin
            r_rec_valid <= 1'b0; r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (abort) begin
            r_state <= S_PARK_COLL;
          end else if (!w_coll_last) begin
            r_coll_idx <= r_coll_idx + IDX_W'(1); r_state <= S_SET_COLL;
          end else if (!w_base_last) begin
            r_coll_idx <= '0; r_base_idx <= r_base_idx + IDX_W'(1); r_state <= S_SET_BASE;
          end else begin
            r_state <= S_PARK_COLL;
          end
        end
        S_PARK_COLL: begin
`ifdef BJT_SWEEP_AVG4_EN
          r_acc <= '0; r_pass <= '0;
`endif
          if (!r_dac_req) begin
            r_dac_req <= 1'b1; r_dac_channel <= COLL_CH; r_dac_code <= '0;
          end else if (dac_ack) begin
            r_dac_req <= 1'b0; r_state <= S_PARK_BASE;
          end
        end
        S_PARK_BASE: begin
          if (!r_dac_req) begin
            r_dac_req <= 1'b1; r_dac_channel <= BASE_CH; r_dac_code <= '0;
          end else if (dac_ack) begin
            r_dac_req <= 1'b0; r_done <= 1'b1; r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dac_req     = r_dac_req;
  assign dac_channel = r_dac_channel;
  assign dac_code    = r_dac_code;
  assign adc_start   = r_adc_start;
  assign rec_valid   = r_rec_valid;
  assign rec_data    = r_rec_data;
  assign done        = r_done;
  assign busy        = (r_state != S_IDLE);
  assign dbg_state   = r_state;
endmodule

// File: tb/tb_bjt_sweep_scheduler.sv
// Bench for bjt_sweep_scheduler: DAC/ADC responders, record and DAC-write scoreboards.
module tb_bjt_sweep_scheduler;
  localparam int DAC_W = 16, ADC_W = 12, IDX_W = 8, SETTLE_W = 16;
  localparam int REC_W = 2*IDX_W+ADC_W;
  localparam logic [1:0] BASE_CH = 2'd0, COLL_CH = 2'd1;
`ifdef BJT_SWEEP_AVG4_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif

  logic globalclock, rst, start, abort;
  logic [DAC_W-1:0] base_start, base_step, coll_start, coll_step;
  logic [IDX_W-1:0] base_count, coll_count;
  logic [SETTLE_W-1:0] settle_cycles;
  logic dac_req, dac_ack, adc_start, adc_done, rec_valid, rec_ready, busy, done;
  logic [1:0] dac_channel;
  logic [DAC_W-1:0] dac_code;
  logic [ADC_W-1:0] adc_data;
  logic [REC_W-1:0] rec_data;
  logic [3:0] dbg_state;

  int n_checks = 0, n_fail = 0;
  logic [DAC_W+1:0] dac_q[$];
  logic [REC_W-1:0] exp_q[$];
  logic [ADC_W-1:0] adc_q[$];
  int dac_dly_min = 0, dac_dly_max = 3;
  bit adc_auto = 1;
  int done_cnt = 0, adc_start_cnt = 0, rec_cnt = 0, stray_req = 0;

  wire [50:0] w_outs = {dac_req, dac_channel, dac_code, adc_start, rec_valid, rec_data, busy, done};

  bjt_sweep_scheduler dut (
    .globalclock(globalclock), .rst(rst), .start(start), .abort(abort),
    .base_start(base_start), .base_step(base_step), .base_count(base_count),
    .coll_start(coll_start), .coll_step(coll_step), .coll_count(coll_count),
    .settle_cycles(settle_cycles),
    .dac_req(dac_req), .dac_channel(dac_channel), .dac_code(dac_code), .dac_ack(dac_ack),
    .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
    .rec_valid(rec_valid), .rec_data(rec_data), .rec_ready(rec_ready),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial begin
    globalclock = 1'b0;
    forever #5 globalclock = ~globalclock;
  end
  initial begin
    #400000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DAC_W-1:0] model_code(input int s, input int i, input int st);
    longint v;
    v = longint'(s) + longint'(i) * longint'(st);
    return (v > 64'd65535) ? 16'hFFFF : DAC_W'(v);
  endfunction

  // DAC serializer model: checks each write against the expected queue, acks after a delay.
  initial begin : dac_resp
    logic [DAC_W+1:0] got;
    dac_ack = 1'b0;
    forever begin
      @(negedge globalclock);
      if (dac_req) begin
        got = {dac_channel, dac_code};
        if (dac_q.size() == 0) chk("dac_unexpected", 1, 0);
        else chk("dac_write", got, dac_q.pop_front());
        repeat ($urandom_range(dac_dly_min, dac_dly_max)) @(negedge globalclock);
        chk("dac_stable", {dac_req, dac_channel, dac_code}, {1'b1, got});
        dac_ack = 1'b1;
        @(posedge globalclock); #1 dac_ack = 1'b0;
        @(negedge globalclock);
        chk("dac_req_drop", dac_req, 0);
      end
    end
  end

  // ADC model: answers adc_start with the next queued sample; also issues stray done pulses.
  initial begin : adc_resp
    int sd;
    sd = 0;
    adc_done = 1'b0; adc_data = '0;
    forever begin
      @(negedge globalclock);
      if (stray_req != sd) begin
        sd++;
        adc_data = 12'hABC; adc_done = 1'b1;
        @(posedge globalclock); #1 adc_done = 1'b0;
      end else if (adc_start) begin
        adc_start_cnt++;
        if (adc_auto) begin
          @(negedge globalclock);
          chk("adc_start_pulse", adc_start, 0);
          repeat ($urandom_range(0, 4)) @(negedge globalclock);
          if (adc_q.size() == 0) begin
            chk("adc_unexpected", 1, 0);
            adc_data = '0;
          end else adc_data = adc_q.pop_front();
          adc_done = 1'b1;
          @(posedge globalclock); #1 adc_done = 1'b0; adc_data = ADC_W'($urandom);
        end
      end
    end
  end

  // record scoreboard and done counter
  initial forever begin
    @(negedge globalclock);
    if (done) done_cnt++;
    if (rec_valid && rec_ready) begin
      rec_cnt++;
      if (exp_q.size() == 0) chk("rec_unexpected", 1, 0);
      else chk("rec_data", rec_data, exp_q.pop_front());
    end
  end

  task automatic set_cfg(input int bs, input int bst, input int bc,
                         input int cs, input int cst, input int cc, input int st);
    base_start = DAC_W'(bs); base_step = DAC_W'(bst); base_count = IDX_W'(bc);
    coll_start = DAC_W'(cs); coll_step = DAC_W'(cst); coll_count = IDX_W'(cc);
    settle_cycles = SETTLE_W'(st);
  endtask

  task automatic push_rec(input int b, input int c, input logic [ADC_W-1:0] s);
    logic [IDX_W-1:0] b8, c8;
    b8 = IDX_W'(b); c8 = IDX_W'(c);
    exp_q.push_back({b8, c8, s});
  endtask

  // Expected DAC writes, ADC samples and records for a full sweep.
  task automatic plan_sweep(input int bs, input int bst, input int bc,
                            input int cs, input int cst, input int cc);
    logic [ADC_W+1:0] sum;
    logic [ADC_W-1:0] d;
    if (bc != 0 && cc != 0) begin
      for (int b = 0; b < bc; b++) begin
        dac_q.push_back({BASE_CH, model_code(bs, b, bst)});
        for (int c = 0; c < cc; c++) begin
          dac_q.push_back({COLL_CH, model_code(cs, c, cst)});
          sum = '0;
          for (int k = 0; k < NCONV; k++) begin
            d = ADC_W'($urandom_range(0, 4095));
            adc_q.push_back(d);
            sum = sum + (ADC_W+2)'(d);
          end
          push_rec(b, c, (NCONV == 4) ? sum[ADC_W+1:2] : sum[ADC_W-1:0]);
        end
      end
    end
    dac_q.push_back({COLL_CH, 16'h0000});
    dac_q.push_back({BASE_CH, 16'h0000});
  endtask

  task automatic pulse_start(input bit expect_accept);
    @(posedge globalclock); #1 start = 1'b1;
    @(posedge globalclock); #1 start = 1'b0;
    if (expect_accept) chk("start_latency", dac_req, 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c0;
    c0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == c0; i++) @(negedge globalclock);
    repeat (4) @(negedge globalclock);
    chk({tag, "_done_count"}, done_cnt - c0, 1);
    chk({tag, "_busy_low"}, busy, 0);
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_dac_q_left"}, dac_q.size(), 0);
    chk({tag, "_exp_q_left"}, exp_q.size(), 0);
    chk({tag, "_adc_q_left"}, adc_q.size(), 0);
    dac_q.delete(); exp_q.delete(); adc_q.delete();
  endtask

  initial begin : main
    int r0, a0, cyc, t_req, t_adc;
    int rbs, rbst, rbc, rcs, rcst, rcc;
    logic [REC_W-1:0] held;
    bit stable, seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0; rec_ready = 1'b1;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge globalclock);
    #1 chk("reset_outputs", w_outs, 0);
    rst = 1'b0;
    @(posedge globalclock); #1 chk("idle_outputs", w_outs, 0);

    // basic sweep; config scrambled after start must not matter
    set_cfg(16'h1000, 16'h0800, 2, 16'h0000, 16'h4000, 3, 5);
    plan_sweep(16'h1000, 16'h0800, 2, 16'h0000, 16'h4000, 3);
    r0 = rec_cnt;
    pulse_start(1);
    set_cfg($urandom, $urandom, $urandom_range(1, 9), $urandom, $urandom, $urandom_range(1, 9), 1);
    wait_done("basic", 3000);
    chk("basic_rec_count", rec_cnt - r0, 6);
    end_checks("basic");

    // saturation of collector code
    set_cfg(16'h0100, 0, 1, 16'hF000, 16'h2000, 2, 2);
    plan_sweep(16'h0100, 0, 1, 16'hF000, 16'h2000, 2);
    pulse_start(1);
    wait_done("sat", 2000);
    end_checks("sat");

    // settle time: cycles from the collector ack to adc_start are settle+1
    for (int s = 0; s < 8; s += 7) begin
      set_cfg(16'h0200, 0, 1, 16'h0300, 0, 1, s);
      plan_sweep(16'h0200, 0, 1, 16'h0300, 0, 1);
      pulse_start(1);
      cyc = 0; t_req = -100; t_adc = 0; seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
        @(negedge globalclock); cyc++;
        if (dac_req && dac_channel == COLL_CH) t_req = cyc;
        if (adc_start) begin t_adc = cyc; seen = 1'b1; end
      end
      chk("settle_gap", t_adc - t_req, s + 1);
      wait_done("settle", 2000);
      end_checks("settle");
    end

    // fixed-sample point (averaged build: 100..103 -> 101)
    set_cfg(16'h0010, 0, 1, 16'h0020, 0, 1, 1);
    dac_q.push_back({BASE_CH, 16'h0010});
    dac_q.push_back({COLL_CH, 16'h0020});
    for (int k = 0; k < NCONV; k++) adc_q.push_back(ADC_W'(100 + k));
    push_rec(0, 0, (NCONV == 4) ? 12'd101 : 12'd100);
    dac_q.push_back({COLL_CH, 16'h0000});
    dac_q.push_back({BASE_CH, 16'h0000});
    pulse_start(1);
    wait_done("fixed", 2000);
    end_checks("fixed");

    // backpressure: record held for 10 cycles with no new conversion
    rec_ready = 1'b0;
    set_cfg(16'h0400, 0, 1, 16'h0500, 0, 1, 2);
    plan_sweep(16'h0400, 0, 1, 16'h0500, 0, 1);
    r0 = rec_cnt;
    pulse_start(1);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge globalclock);
      if (rec_valid) seen = 1'b1;
    end
    chk("bp_valid_seen", seen, 1);
    held = rec_data; a0 = adc_start_cnt; stable = 1'b1;
    repeat (10) begin
      @(negedge globalclock);
      if (!rec_valid || rec_data !== held) stable = 1'b0;
    end
    chk("bp_hold", stable, 1);
    chk("bp_no_adc_start", adc_start_cnt - a0, 0);
    @(posedge globalclock); #1 rec_ready = 1'b1;
    wait_done("bp", 2000);
    chk("bp_rec_count", rec_cnt - r0, 1);
    end_checks("bp");

    // empty sweep: only the two park writes
    set_cfg(16'h1234, 16'h0001, 3, 16'h4321, 16'h0001, 0, 3);
    plan_sweep(16'h1234, 16'h0001, 3, 16'h4321, 16'h0001, 0);
    r0 = rec_cnt;
    pulse_start(1);
    wait_done("empty", 1000);
    chk("empty_rec_count", rec_cnt - r0, 0);
    end_checks("empty");

    // abort while the collector write is outstanding; concurrent start ignored
    dac_dly_min = 8; dac_dly_max = 8;
    set_cfg(16'h0300, 16'h0100, 2, 16'h0700, 16'h0100, 2, 4);
    dac_q.push_back({BASE_CH, 16'h0300});
    dac_q.push_back({COLL_CH, 16'h0700});
    dac_q.push_back({COLL_CH, 16'h0000});
    dac_q.push_back({BASE_CH, 16'h0000});
    r0 = rec_cnt;
    pulse_start(1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge globalclock);
      if (dac_req && dac_channel == COLL_CH) seen = 1'b1;
    end
    chk("abort_reached_coll", seen, 1);
    @(posedge globalclock); #1 abort = 1'b1; start = 1'b1;
    @(posedge globalclock); #1 abort = 1'b0; start = 1'b0;
    @(negedge globalclock);
    chk("abort_frame_kept", {dac_req, dac_channel}, {1'b1, COLL_CH});
    chk("abort_no_rec_adc", {rec_valid, adc_start}, 0);
    wait_done("abort", 1000);
    repeat (20) @(negedge globalclock);
    chk("abort_stays_idle", busy, 0);
    chk("abort_rec_count", rec_cnt - r0, 0);
    end_checks("abort");
    dac_dly_min = 0; dac_dly_max = 3;

    // reset during WAIT_ADC, then a late adc_done
    adc_auto = 1'b0;
    set_cfg(16'h0600, 0, 1, 16'h0800, 0, 1, 1);
    dac_q.push_back({BASE_CH, 16'h0600});
    dac_q.push_back({COLL_CH, 16'h0800});
    a0 = adc_start_cnt;
    pulse_start(1);
    for (int i = 0; i < 300 && adc_start_cnt == a0; i++) @(negedge globalclock);
    chk("rst_adc_started", adc_start_cnt - a0, 1);
    repeat (2) @(negedge globalclock);
    @(posedge globalclock); #1 rst = 1'b1;
    @(posedge globalclock); #1 chk("rst_outputs_zero", w_outs, 0);
    rst = 1'b0;
    stray_req++;
    repeat (10) @(negedge globalclock);
    chk("rst_stray_done_ignored", {rec_valid, busy, dac_req}, 0);
    adc_auto = 1'b1;
    end_checks("rst");

    // random sweeps
    for (int n = 0; n < 3; n++) begin
      rbs = $urandom_range(0, 65535); rbst = $urandom_range(0, 65535); rbc = $urandom_range(1, 3);
      rcs = $urandom_range(0, 65535); rcst = $urandom_range(0, 65535); rcc = $urandom_range(1, 3);
      set_cfg(rbs, rbst, rbc, rcs, rcst, rcc, $urandom_range(0, 3));
      plan_sweep(rbs, rbst, rbc, rcs, rcst, rcc);
      pulse_start(1);
      wait_done("rand", 4000);
      end_checks("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
